// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - parallel ADC clock/power control, sample capture and read FIFO
module adc_capture #(
    parameter int DATA_WIDTH = 10,
    parameter int CLK_DIV    = 4,
    parameter int PIPE_DLY   = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          enable,
    input  logic                          fmt_twos,
    input  logic [DATA_WIDTH-1:0]         A_Data_pin,
    output logic                          A_Clk_pin,
    output logic                          A_PWRDN_pin,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q;
    logic [CW-1:0]         div_q, div_d;
    logic                  a_clk_q, a_clk_d;
    logic                  pwrdn_q;
    logic [3:0]            discard_q;
    logic                  cap_valid_q;
    logic [DATA_WIDTH-1:0] cap_data_q;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  ovf_q;
    logic                  full, empty, push, pop;

    // Divider next state: wraps modulo CLK_DIV, clock high for the first half of the period
    always_comb begin
        div_d   = (div_q == CW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
        a_clk_d = (div_d < CW'(CLK_DIV / 2));
    end

    // Run/idle control, ADC pin drive, capture at the end of the ADC clock low phase
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            a_clk_q     <= 1'b0;
            pwrdn_q     <= 1'b1;
            discard_q   <= 4'(PIPE_DLY);
            cap_valid_q <= 1'b0;
            cap_data_q  <= '0;
        end else begin
            cap_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= RUN;
                        div_q   <= '0;
                        a_clk_q <= 1'b1;
                        pwrdn_q <= 1'b0;
                    end else begin
                        div_q     <= '0;
                        a_clk_q   <= 1'b0;
                        pwrdn_q   <= 1'b1;
                        discard_q <= 4'(PIPE_DLY);
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_q   <= IDLE;
                        div_q     <= '0;
                        a_clk_q   <= 1'b0;
                        pwrdn_q   <= 1'b1;
                        discard_q <= 4'(PIPE_DLY);
                    end else begin
                        div_q   <= div_d;
                        a_clk_q <= a_clk_d;
                        if (div_q == CW'(CLK_DIV - 1)) begin
                            // The first PIPE_DLY samples after start are stale pipeline contents
                            if (discard_q != 4'd0) begin
                                discard_q <= discard_q - 4'd1;
                            end else begin
                                cap_valid_q <= 1'b1;
                                cap_data_q  <= {A_Data_pin[DATA_WIDTH-1] ^ fmt_twos,
                                                A_Data_pin[DATA_WIDTH-2:0]};
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // FIFO handshake: a full FIFO still accepts a push when a pop frees a slot on the same edge
    always_comb begin
        full  = (count_q == (AW+1)'(FIFO_DEPTH));
        empty = (count_q == '0);
        pop   = rd_en && !empty;
        push  = cap_valid_q && (!full || pop);
    end

    // Sample storage, not reset: occupancy is tracked by the pointers and count
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cap_data_q;
        end
    end

    // FIFO pointers, occupancy, read port and sticky overflow
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rd_valid_q <= pop;
            if (pop) begin
                rd_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A new drop takes priority over a clear on the same edge
            if (cap_valid_q && !push) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign A_Clk_pin   = a_clk_q;
    assign A_PWRDN_pin = pwrdn_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign fifo_empty  = empty;
    assign fifo_full   = full;
    assign fifo_count  = count_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_adc_capture.sv
// tb/tb_adc_capture.sv - directed self-checking bench for adc_capture
module tb_adc_capture;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       enable = 1'b0;
    logic       fmt_twos = 1'b0;
    logic [9:0] A_Data_pin = '0;
    logic       A_Clk_pin;
    logic       A_PWRDN_pin;
    logic       rd_en = 1'b0;
    logic [9:0] rd_data;
    logic       rd_valid;
    logic       fifo_empty;
    logic       fifo_full;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       clr_ovf = 1'b0;

    int         n_tests = 0;
    int         n_fail = 0;
    logic       adc_auto = 1'b0;
    logic [9:0] adc_k = '0;

    adc_capture dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .enable      (enable),
        .fmt_twos    (fmt_twos),
        .A_Data_pin  (A_Data_pin),
        .A_Clk_pin   (A_Clk_pin),
        .A_PWRDN_pin (A_PWRDN_pin),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    always #5 sys_clk = ~sys_clk;

    // ADC model: after the k-th rise of its sample clock the bus carries adc_k
    always @(posedge A_Clk_pin) begin
        #1;
        if (adc_auto) begin
            A_Data_pin = adc_k;
            adc_k      = adc_k + 10'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic wait_cnt(input int n, input string tag);
        int budget = 200;
        while (fifo_count != 5'(n) && budget > 0) begin
            tick();
            budget--;
        end
        check(tag, fifo_count, n);
    endtask

    task automatic pop_check(input logic [9:0] exp, input string tag);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, rd_valid, 1);
        check({tag, "_data"}, rd_data, exp);
    endtask

    logic [9:0] fmt_in  [4] = '{10'h200, 10'h000, 10'h3FF, 10'h155};
    logic       fmt_sel [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [9:0] fmt_exp [4] = '{10'h000, 10'h200, 10'h1FF, 10'h155};

    initial begin
        // reset values
        tick(3);
        check("rst_aclk", A_Clk_pin, 0);
        check("rst_pwrdn", A_PWRDN_pin, 1);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_rdvalid", rd_valid, 0);
        check("rst_rddata", rd_data, 0);
        sys_rst = 1'b1;
        tick(2);

        // capture and discard with the counting ADC model; enable asserted in cycle 0
        adc_auto = 1'b1;
        adc_k    = 10'h000;
        enable   = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("aclk_c%0d", c), A_Clk_pin, ((c - 1) % 4) < 2);
            check($sformatf("pwrdn_c%0d", c), A_PWRDN_pin, 0);
            tick();
        end
        tick(4);
        check("lat_c13_count", fifo_count, 0);
        tick();
        check("lat_c14_count", fifo_count, 1);
        check("lat_c14_empty", fifo_empty, 0);
        wait_cnt(3, "cap_three");
        // disable during the A_Clk high phase
        check("dis_phase_high", A_Clk_pin, 1);
        enable = 1'b0;
        tick();
        check("dis_aclk", A_Clk_pin, 0);
        check("dis_pwrdn", A_PWRDN_pin, 1);
        tick(10);
        check("dis_count", fifo_count, 3);
        pop_check(10'h002, "cap0");
        pop_check(10'h003, "cap1");
        pop_check(10'h004, "cap2");
        check("cap_empty", fifo_empty, 1);

        // read of an empty FIFO
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("er_valid", rd_valid, 0);
        check("er_count", fifo_count, 0);
        check("er_data", rd_data, 10'h004);

        // re-enable discards the pipeline samples again
        adc_k      = 10'h100;
        A_Data_pin = 10'h100;
        enable     = 1'b1;
        wait_cnt(1, "reen_one");
        enable = 1'b0;
        tick(2);
        pop_check(10'h102, "reen");

        // output format conversion on a static bus
        adc_auto = 1'b0;
        for (int i = 0; i < 4; i++) begin
            A_Data_pin = fmt_in[i];
            fmt_twos   = fmt_sel[i];
            enable     = 1'b1;
            wait_cnt(1, $sformatf("fmt%0d_one", i));
            enable = 1'b0;
            tick(2);
            pop_check(fmt_exp[i], $sformatf("fmt%0d", i));
        end
        fmt_twos = 1'b0;

        // overflow: 17 kept samples without reads
        adc_auto   = 1'b1;
        adc_k      = 10'h000;
        A_Data_pin = 10'h000;
        enable     = 1'b1;
        wait_cnt(16, "ovf_fill");
        check("ovf_before", overflow, 0);
        tick(4);
        check("ovf_set", overflow, 1);
        check("ovf_full", fifo_full, 1);
        check("ovf_count", fifo_count, 16);
        enable = 1'b0;
        tick(2);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_clr", overflow, 0);

        // read on the write edge while full: push accepted, count held
        adc_k      = 10'h200;
        A_Data_pin = 10'h200;
        enable     = 1'b1;
        tick(13);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("fullrw_count", fifo_count, 16);
        check("fullrw_ovf", overflow, 0);
        check("fullrw_valid", rd_valid, 1);
        check("fullrw_data", rd_data, 10'h002);
        enable = 1'b0;
        tick(2);
        for (int v = 3; v <= 17; v++) begin
            pop_check(10'(v), $sformatf("drain%0d", v));
        end
        pop_check(10'h202, "drain_last");
        check("drain_empty", fifo_empty, 1);

        // asynchronous reset mid-run with 5 samples buffered
        adc_auto   = 1'b0;
        A_Data_pin = 10'h0AA;
        enable     = 1'b1;
        wait_cnt(5, "arst_fill");
        #2;
        sys_rst = 1'b0;
        #1;
        check("arst_aclk", A_Clk_pin, 0);
        check("arst_pwrdn", A_PWRDN_pin, 1);
        check("arst_empty", fifo_empty, 1);
        check("arst_full", fifo_full, 0);
        check("arst_count", fifo_count, 0);
        check("arst_ovf", overflow, 0);
        check("arst_rddata", rd_data, 0);
        check("arst_rdvalid", rd_valid, 0);
        enable = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        tick(3);
        check("arst_rel_count", fifo_count, 0);
        check("arst_rel_aclk", A_Clk_pin, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_capture.md
# adc_capture

Receive-side companion to the DAC output path: drives the sample clock and power-down of an external 10-bit parallel ADC, captures its output bus, optionally converts offset-binary to two's complement, discards the ADC pipeline-latency samples, and buffers results in a FIFO for the processor-side bus slave to read. Sits between the ADC pins at the FPGA top level and the register/IPIF logic of the ADC peripheral.

## Interface
- DATA_WIDTH, 10, ADC sample width.
- CLK_DIV, 4, sys_clk cycles per ADC clock period; even, ≥2.
- PIPE_DLY, 2, captures discarded after each start (ADC pipeline latency), 0–15.
- FIFO_DEPTH, 16, sample FIFO depth; power of 2.

- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  asynchronous reset, active-low.
- enable  in  1  1 = run ADC and capture; 0 = stop and power down.
- fmt_twos  in  1  1 = invert MSB (offset binary → two's complement); sampled at capture.
- A_Data_pin  in  DATA_WIDTH  ADC output bus.
- A_Clk_pin  out  1  ADC sample clock, registered.
- A_PWRDN_pin  out  1  ADC power-down, active-high, registered.
- rd_en  in  1  pop request.
- rd_data  out  DATA_WIDTH  popped sample.
- rd_valid  out  1  rd_data valid; one-cycle pulse.
- fifo_empty  out  1  FIFO empty.
- fifo_full  out  1  FIFO full.
- fifo_count  out  log2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky: a kept sample was dropped.
- clr_ovf  in  1  clears overflow.

## Operation
- States IDLE, RUN. Reset → IDLE.
- IDLE: A_Clk_pin=0, A_PWRDN_pin=1, div_cnt=0, discard counter=PIPE_DLY. On edge with enable=1: → RUN, div_cnt←0, A_Clk_pin←1, A_PWRDN_pin←0.
- RUN: div_cnt increments modulo CLK_DIV each edge; A_Clk_pin←1 when next div_cnt < CLK_DIV/2, else 0. On edge with enable=0: → IDLE (IDLE outputs next cycle); no capture on that edge.
- Capture: in RUN at edge ending a cycle with div_cnt=CLK_DIV-1 (end of A_Clk low phase, same edge A_Clk rises), A_Data_pin registered; fmt_twos applied (MSB inverted if 1); capture flagged.
- Discard: if discard counter ≠0, flagged capture decrements it and is dropped; else sample pushed to FIFO on the following edge.
- FIFO push when not full, or when full and a read is accepted on the same edge. Full with no read → sample dropped, overflow←1.
- Pop: rd_en=1 and not empty → rd_data/rd_valid registered next cycle; rd_en on empty ignored (rd_valid=0, count unchanged). Simultaneous push and pop: count unchanged.
- overflow set and clr_ovf on same edge: set wins.
- FIFO contents retained across enable toggles; only sys_rst clears them.

## Timing
- Reset values: A_Clk_pin 0, A_PWRDN_pin 1, rd_data 0, rd_valid 0, fifo_empty 1, fifo_full 0, fifo_count 0, overflow 0; state IDLE.
- sys_rst assertion mid-run: all of the above immediately (asynchronous), FIFO emptied, in-flight capture lost; deassertion synchronous-release assumed by top level.
- CLK_DIV=4, enable high in cycle 0: A_Clk_pin 1,1,0,0 in cycles 1–4, repeating; first capture at end of cycle 4.
- Capture at end of cycle T → FIFO write end of T+1 → fifo_empty=0, fifo_count updated in T+2 → rd_en in T+2 gives rd_valid in T+3.
- Steady throughput: one sample per CLK_DIV cycles.
- Re-enable after IDLE restarts divider at 0 and reloads discard counter.

## Test plan
- Reset: assert sys_rst mid-run with 5 samples buffered -> all outputs at reset values immediately, fifo_count=0 after release.
- Capture/discard: CLK_DIV=4, PIPE_DLY=2, ADC model drives 10'h000+k after k-th A_Clk rise, enable -> A_Clk pattern 1100, values for k=0,1 dropped, FIFO reads 10'h002, 10'h003, 10'h004 in order.
- Format: fmt_twos=1, A_Data 10'h200/10'h000/10'h3FF -> rd_data 10'h000/10'h200/10'h1FF; fmt_twos=0 passes unchanged.
- Overflow: no reads, 17 kept samples -> fifo_full=1, fifo_count=16, overflow=1, 17th dropped; clr_ovf -> overflow=0; rd_en on the write edge while full -> write accepted, count stays 16, overflow unchanged.
- Empty read: rd_en with FIFO empty -> rd_valid=0, fifo_count=0, rd_data unchanged.
- Disable mid-run: enable=0 in A_Clk high phase -> next cycle A_Clk_pin=0, A_PWRDN_pin=1, no further pushes, FIFO contents readable; re-enable discards 2 samples again.
